// File: rtl/tlb_op_sequencer.sv
// Serialises TLB maintenance instructions onto the single read/write port of
// the TLB entry array: entry walks for search/invalidate, direct RD/WR/FILL.
module tlb_op_sequencer #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             tlbsrch_valid,
    input  logic             tlbrd_valid,
    input  logic             tlbwr_valid,
    input  logic             tlbfill_valid,
    input  logic             invtlb_valid,
    output logic             tlbsrch_ready,
    output logic             tlbrd_ready,
    output logic             tlbwr_ready,
    output logic             tlbfill_ready,
    output logic             invtlb_ready,
    input  logic [4:0]       invtlb_op,
    input  logic [9:0]       invtlb_asid,
    input  logic [18:0]      invtlb_va,
    input  logic [IDX_W-1:0] csr_index,
    input  logic [9:0]       csr_asid,
    input  logic [18:0]      csr_vppn,
    output logic [IDX_W-1:0] tlb_idx,
    output logic             tlb_re,
    output logic             tlb_we,
    output logic             tlb_wsel,
    input  logic [18:0]      tlb_r_vppn,
    input  logic [9:0]       tlb_r_asid,
    input  logic             tlb_r_g,
    input  logic             tlb_r_e,
    output logic             srch_hit,
    output logic [IDX_W-1:0] srch_index,
    output logic             inv_illegal,
    output logic             busy
);

    typedef enum logic [3:0] {
        IDLE, RD, RD_RESP, WR, S_RD, S_CMP, I_RD, I_CMP, I_WR, I_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             is_fill_q, is_fill_d;
    logic [4:0]       op_q, op_d;
    logic [9:0]       asid_q, asid_d;
    logic [18:0]      vppn_q, vppn_d;
    logic             srch_hit_q, srch_hit_d;
    logic [IDX_W-1:0] srch_index_q, srch_index_d;
    logic             inv_illegal_q, inv_illegal_d;

    logic last_entry, asid_m, vppn_m, srch_match, inv_match;

    assign last_entry = (i_q == IDX_W'(TLBNUM - 1));
    assign asid_m     = (tlb_r_asid == asid_q);
    assign vppn_m     = (tlb_r_vppn == vppn_q);
    assign srch_match = tlb_r_e & (tlb_r_g | asid_m) & vppn_m;

    always_comb begin
        case (op_q)
            5'd0, 5'd1: inv_match = 1'b1;
            5'd2:       inv_match = tlb_r_e & tlb_r_g;
            5'd3:       inv_match = tlb_r_e & ~tlb_r_g;
            5'd4:       inv_match = tlb_r_e & ~tlb_r_g & asid_m;
            5'd5:       inv_match = tlb_r_e & ~tlb_r_g & asid_m & vppn_m;
            5'd6:       inv_match = tlb_r_e & (tlb_r_g | asid_m) & vppn_m;
            default:    inv_match = 1'b0;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        index_d       = index_q;
        is_fill_d     = is_fill_q;
        op_d          = op_q;
        asid_d        = asid_q;
        vppn_d        = vppn_q;
        fill_cnt_d    = fill_cnt_q + IDX_W'(1);
        srch_hit_d    = srch_hit_q;
        srch_index_d  = srch_index_q;
        inv_illegal_d = inv_illegal_q;
        tlbsrch_ready = 1'b0;
        tlbrd_ready   = 1'b0;
        tlbwr_ready   = 1'b0;
        tlbfill_ready = 1'b0;
        invtlb_ready  = 1'b0;
        tlb_idx       = '0;
        tlb_re        = 1'b0;
        tlb_we        = 1'b0;
        tlb_wsel      = 1'b0;

        case (state_q)
            IDLE: begin
                i_d = '0;
                if (tlbsrch_valid) begin
                    asid_d  = csr_asid;
                    vppn_d  = csr_vppn;
                    state_d = S_RD;
                end else if (tlbrd_valid) begin
                    index_d = csr_index;
                    state_d = RD;
                end else if (tlbwr_valid) begin
                    index_d   = csr_index;
                    is_fill_d = 1'b0;
                    state_d   = WR;
                end else if (tlbfill_valid) begin
                    index_d   = fill_cnt_q;
                    is_fill_d = 1'b1;
                    state_d   = WR;
                end else if (invtlb_valid) begin
                    op_d    = invtlb_op;
                    asid_d  = invtlb_asid;
                    vppn_d  = invtlb_va;
                    state_d = (invtlb_op > 5'd6) ? I_DONE : I_RD;
                end
            end
            RD: begin
                tlb_re  = 1'b1;
                tlb_idx = index_q;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                tlbrd_ready = 1'b1;
                state_d     = IDLE;
            end
            WR: begin
                tlb_we        = 1'b1;
                tlb_idx       = index_q;
                tlbwr_ready   = ~is_fill_q;
                tlbfill_ready = is_fill_q;
                state_d       = IDLE;
            end
            S_RD: begin
                tlb_re  = 1'b1;
                tlb_idx = i_q;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (srch_match || last_entry) begin
                    tlbsrch_ready = 1'b1;
                    srch_hit_d    = srch_match;
                    srch_index_d  = srch_match ? i_q : '0;
                    state_d       = IDLE;
                end else begin
                    i_d     = i_q + IDX_W'(1);
                    state_d = S_RD;
                end
            end
            I_RD: begin
                tlb_re  = 1'b1;
                tlb_idx = i_q;
                state_d = I_CMP;
            end
            I_CMP: begin
                if (inv_match) begin
                    state_d = I_WR;
                end else if (last_entry) begin
                    state_d = I_DONE;
                end else begin
                    i_d     = i_q + IDX_W'(1);
                    state_d = I_RD;
                end
            end
            I_WR: begin
                tlb_we   = 1'b1;
                tlb_wsel = 1'b1;
                tlb_idx  = i_q;
                if (last_entry) begin
                    state_d = I_DONE;
                end else begin
                    i_d     = i_q + IDX_W'(1);
                    state_d = I_RD;
                end
            end
            I_DONE: begin
                invtlb_ready  = 1'b1;
                inv_illegal_d = (op_q > 5'd6);
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts without completing; array enables above are left intact.
        if (flush) begin
            state_d       = IDLE;
            tlbsrch_ready = 1'b0;
            tlbrd_ready   = 1'b0;
            tlbwr_ready   = 1'b0;
            tlbfill_ready = 1'b0;
            invtlb_ready  = 1'b0;
            srch_hit_d    = srch_hit_q;
            srch_index_d  = srch_index_q;
            inv_illegal_d = inv_illegal_q;
        end
    end

    // Results show their new value in the ready cycle and hold afterwards.
    assign srch_hit    = srch_hit_d;
    assign srch_index  = srch_index_d;
    assign inv_illegal = inv_illegal_d;
    assign busy        = (state_q != IDLE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            i_q           <= '0;
            index_q       <= '0;
            fill_cnt_q    <= '0;
            is_fill_q     <= 1'b0;
            op_q          <= '0;
            asid_q        <= '0;
            vppn_q        <= '0;
            srch_hit_q    <= 1'b0;
            srch_index_q  <= '0;
            inv_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            index_q       <= index_d;
            fill_cnt_q    <= fill_cnt_d;
            is_fill_q     <= is_fill_d;
            op_q          <= op_d;
            asid_q        <= asid_d;
            vppn_q        <= vppn_d;
            srch_hit_q    <= srch_hit_d;
            srch_index_q  <= srch_index_d;
            inv_illegal_q <= inv_illegal_d;
        end
    end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer: a small TLB array model answers reads,
// and each scenario checks latency, array accesses and result registers.
module tb_tlb_op_sequencer;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             flush = 1'b0;
    logic             tlbsrch_valid = 1'b0, tlbrd_valid = 1'b0, tlbwr_valid = 1'b0;
    logic             tlbfill_valid = 1'b0, invtlb_valid = 1'b0;
    logic             tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready;
    logic [4:0]       invtlb_op = '0;
    logic [9:0]       invtlb_asid = '0;
    logic [18:0]      invtlb_va = '0;
    logic [IDX_W-1:0] csr_index = '0;
    logic [9:0]       csr_asid = '0;
    logic [18:0]      csr_vppn = '0;
    logic [IDX_W-1:0] tlb_idx;
    logic             tlb_re, tlb_we, tlb_wsel;
    logic [18:0]      tlb_r_vppn = '0;
    logic [9:0]       tlb_r_asid = '0;
    logic             tlb_r_g = 1'b0, tlb_r_e = 1'b0;
    logic             srch_hit;
    logic [IDX_W-1:0] srch_index;
    logic             inv_illegal, busy;

    tlb_op_sequencer #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .tlbsrch_valid(tlbsrch_valid), .tlbrd_valid(tlbrd_valid),
        .tlbwr_valid(tlbwr_valid), .tlbfill_valid(tlbfill_valid),
        .invtlb_valid(invtlb_valid),
        .tlbsrch_ready(tlbsrch_ready), .tlbrd_ready(tlbrd_ready),
        .tlbwr_ready(tlbwr_ready), .tlbfill_ready(tlbfill_ready),
        .invtlb_ready(invtlb_ready),
        .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va),
        .csr_index(csr_index), .csr_asid(csr_asid), .csr_vppn(csr_vppn),
        .tlb_idx(tlb_idx), .tlb_re(tlb_re), .tlb_we(tlb_we), .tlb_wsel(tlb_wsel),
        .tlb_r_vppn(tlb_r_vppn), .tlb_r_asid(tlb_r_asid),
        .tlb_r_g(tlb_r_g), .tlb_r_e(tlb_r_e),
        .srch_hit(srch_hit), .srch_index(srch_index),
        .inv_illegal(inv_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Array contents are set up by the stimulus; the model only answers reads.
    logic [18:0] mem_vppn [TLBNUM];
    logic [9:0]  mem_asid [TLBNUM];
    logic        mem_g    [TLBNUM];
    logic        mem_e    [TLBNUM];

    always @(posedge clk) begin
        if (tlb_re) begin
            tlb_r_vppn <= mem_vppn[tlb_idx];
            tlb_r_asid <= mem_asid[tlb_idx];
            tlb_r_g    <= mem_g[tlb_idx];
            tlb_r_e    <= mem_e[tlb_idx];
        end
    end

    // Reference fill counter, counting edges since reset release.
    logic [IDX_W-1:0] ref_fill;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ref_fill <= '0;
        else       ref_fill <= ref_fill + IDX_W'(1);
    end

    int n_re = 0, n_we = 0, n_inv_we = 0, n_srch_rdy = 0, n_rd_rdy = 0, n_fill_rdy = 0;
    logic [IDX_W-1:0] inv_log [16];

    always @(negedge clk) begin
        if (tlb_re) n_re <= n_re + 1;
        if (tlb_we) n_we <= n_we + 1;
        if (tlb_we && tlb_wsel) begin
            inv_log[n_inv_we % 16] <= tlb_idx;
            n_inv_we <= n_inv_we + 1;
        end
        if (tlbsrch_ready) n_srch_rdy <= n_srch_rdy + 1;
        if (tlbrd_ready)   n_rd_rdy   <= n_rd_rdy + 1;
        if (tlbfill_ready) n_fill_rdy <= n_fill_rdy + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return tlbsrch_ready;
            1: return tlbrd_ready;
            2: return tlbwr_ready;
            3: return tlbfill_ready;
            default: return invtlb_ready;
        endcase
    endfunction

    // mask bits: 0 srch, 1 rd, 2 wr, 3 fill, 4 inv. Returns after accept edge T.
    task automatic issue(input logic [4:0] mask);
        @(negedge clk);
        tlbsrch_valid = mask[0];
        tlbrd_valid   = mask[1];
        tlbwr_valid   = mask[2];
        tlbfill_valid = mask[3];
        invtlb_valid  = mask[4];
        @(posedge clk);
        #1;
        {tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid} = '0;
    endtask

    // lat = k when the ready is seen in cycle T+k; budget expiry counts as a failure.
    task automatic wait_rdy(input int sel, input int budget, output int lat);
        bit done = 0;
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
            if (rdy(sel)) done = 1;
        end
        if (!done) check("ready_timeout", 32'(lat), 32'(budget + 1));
    endtask

    task automatic mem_default();
        for (int k = 0; k < TLBNUM; k++) begin
            mem_vppn[k] = 19'h100 + 19'(k);
            mem_asid[k] = '0;
            mem_g[k]    = 1'b0;
            mem_e[k]    = 1'b1;
        end
        mem_vppn[9] = 19'h1234;
        mem_asid[9] = 10'd3;
    endtask

    int lat, b_re, b_we, b_inv, b_srch, b_rd, b_fill;

    initial begin
        mem_default();
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_enables", {29'd0, tlb_re, tlb_we, tlb_wsel}, 0);
        check("rst_results", {27'd0, srch_hit, srch_index}, 0);
        check("rst_readies", {27'd0, tlbsrch_ready, tlbrd_ready, tlbwr_ready,
                              tlbfill_ready, invtlb_ready}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // TLBWR to entry 5
        csr_index = 4'd5;
        issue(5'b00100);
        wait_rdy(2, 8, lat);
        check("wr_latency", 32'(lat), 1);
        check("wr_we_wsel", {30'd0, tlb_we, tlb_wsel}, 32'b10);
        check("wr_idx", 32'(tlb_idx), 5);

        // TLBFILL uses the fill counter value at the accept edge
        issue(5'b01000);
        wait_rdy(3, 8, lat);
        check("fill_latency", 32'(lat), 1);
        check("fill_idx", 32'(tlb_idx), 32'(ref_fill - IDX_W'(1)));

        // TLBSRCH hit at entry 9, then miss with a different ASID
        csr_vppn = 19'h1234;
        csr_asid = 10'd3;
        issue(5'b00001);
        wait_rdy(0, 40, lat);
        check("srch_hit_latency", 32'(lat), 20);
        check("srch_hit", 32'(srch_hit), 1);
        check("srch_index", 32'(srch_index), 9);
        @(negedge clk);
        check("srch_hold", {27'd0, srch_hit, srch_index}, {27'd0, 1'b1, 4'd9});
        csr_asid = 10'd4;
        issue(5'b00001);
        wait_rdy(0, 40, lat);
        check("srch_miss_latency", 32'(lat), 32);
        check("srch_miss", {27'd0, srch_hit, srch_index}, 0);

        // INVTLB op 2: global entries 2 and 7 get cleared
        for (int k = 0; k < TLBNUM; k++) mem_g[k] = (k == 2 || k == 7);
        @(posedge clk);
        b_inv = n_inv_we;
        invtlb_op = 5'd2;
        issue(5'b10000);
        wait_rdy(4, 50, lat);
        check("inv2_latency", 32'(lat), 35);
        check("inv2_illegal", 32'(inv_illegal), 0);
        @(posedge clk);
        check("inv2_writes", 32'(n_inv_we - b_inv), 2);
        check("inv2_first_idx", 32'(inv_log[b_inv % 16]), 2);
        check("inv2_second_idx", 32'(inv_log[(b_inv + 1) % 16]), 7);
        mem_default();

        // INVTLB op 7 is illegal: immediate completion, no array access
        b_re = n_re; b_we = n_we;
        invtlb_op = 5'd7;
        issue(5'b10000);
        wait_rdy(4, 8, lat);
        check("inv7_latency", 32'(lat), 1);
        check("inv7_illegal", 32'(inv_illegal), 1);
        @(posedge clk);
        check("inv7_no_access", 32'((n_re - b_re) + (n_we - b_we)), 0);

        // Search beats read; a fill while busy is ignored
        csr_asid = 10'd3;
        csr_index = 4'd1;
        b_re = n_re; b_we = n_we; b_rd = n_rd_rdy; b_fill = n_fill_rdy;
        issue(5'b00011);
        @(negedge clk);
        tlbfill_valid = 1'b1;
        @(negedge clk);
        tlbfill_valid = 1'b0;
        wait_rdy(0, 40, lat);
        check("prio_srch_latency", 32'(lat + 2), 20);
        check("prio_srch_index", 32'(srch_index), 9);
        repeat (4) @(negedge clk);
        check("prio_no_rd", 32'(n_rd_rdy - b_rd), 0);
        check("prio_reads", 32'(n_re - b_re), 10);
        check("busy_fill_ignored", 32'((n_we - b_we) + (n_fill_rdy - b_fill)), 0);
        check("prio_idle", 32'(busy), 0);

        // Flush in S_CMP of entry 4
        csr_asid = 10'd4;
        b_srch = n_srch_rdy;
        issue(5'b00001);
        repeat (9) @(negedge clk);
        check("flush_s_rd4", {27'd0, tlb_re, tlb_idx}, {27'd0, 1'b1, 4'd4});
        @(negedge clk);
        check("flush_pre_busy", {30'd0, busy, tlb_re}, 32'b10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("flush_no_ready", 32'(n_srch_rdy - b_srch), 0);
        check("flush_result_held", {27'd0, srch_hit, srch_index}, {27'd0, 1'b1, 4'd9});
        b_re = n_re;
        csr_index = 4'd3;
        issue(5'b00010);
        wait_rdy(1, 8, lat);
        check("rd_latency", 32'(lat), 2);
        check("rd_data", 32'(tlb_r_vppn), 32'h103);
        @(posedge clk);
        check("rd_reads", 32'(n_re - b_re), 1);

        // Reset in the middle of an invalidate walk
        invtlb_op = 5'd0;
        issue(5'b10000);
        repeat (5) @(negedge clk);
        check("walk_busy", 32'(busy), 1);
        rstn = 1'b0;
        #1;
        check("rst_mid_walk", {29'd0, busy, tlb_re, tlb_we}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_op_sequencer.md
# tlb_op_sequencer

- Sequences the TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued by the EX-stage privilege unit onto the single read/write port of the TLB entry array.
- Sits between the privilege unit's `*_valid`/`*_ready` handshake and the TLB array.
- Walks the array entry by entry for search and invalidate, selects the fill index, and reports completion with one-cycle ready pulses.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries (power of two)
- IDX_W, 4, log2(TLBNUM)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort from pipeline flush
- tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid  in  1 each  request pulses
- tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready  out  1 each  one-cycle completion pulses
- invtlb_op  in  5  INVTLB op code
- invtlb_asid  in  10  ASID operand
- invtlb_va  in  19  VPPN operand
- csr_index  in  IDX_W  TLBIDX.index, for TLBRD/TLBWR
- csr_asid  in  10  ASID.asid, for TLBSRCH
- csr_vppn  in  19  TLBEHI.vppn, for TLBSRCH
- tlb_idx  out  IDX_W  array index
- tlb_re  out  1  array read enable; data valid the next cycle
- tlb_we  out  1  array write enable
- tlb_wsel  out  1  0 = write full entry from CSRs, 1 = clear E bit only
- tlb_r_vppn  in  19  read data
- tlb_r_asid  in  10  read data
- tlb_r_g  in  1  read data
- tlb_r_e  in  1  read data
- srch_hit  out  1  search result, valid with tlbsrch_ready
- srch_index  out  IDX_W  search result, valid with tlbsrch_ready
- inv_illegal  out  1  op > 6, valid with invtlb_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD, RD_RESP, WR, S_RD, S_CMP, I_RD, I_CMP, I_WR, I_DONE.
- IDLE, request accept:
  - Valids are sampled only in IDLE; a valid while busy is ignored.
  - Priority when several valids are set: srch > rd > wr > fill > inv.
  - On accept, operands (op, asid, va, csr_index, csr_asid, csr_vppn) are latched, along with the fill counter value for TLBFILL.
- TLBRD: IDLE→RD. RD drives tlb_re=1, tlb_idx=index_q. RD→RD_RESP. RD_RESP pulses tlbrd_ready while tlb_r_* is valid. RD_RESP→IDLE.
- TLBWR / TLBFILL: IDLE→WR. WR drives tlb_we=1, tlb_wsel=0, tlb_idx=index_q (TLBFILL uses the latched fill counter). The matching ready pulses in the same cycle. WR→IDLE.
- Fill counter:
  - Free-running IDX_W-bit counter, increments every clock and wraps TLBNUM-1→0.
  - Reset value 0.
- TLBSRCH:
  - Entry counter i starts at 0. S_RD drives tlb_re=1, tlb_idx=i; S_RD→S_CMP.
  - Hit condition: tlb_r_e & (tlb_r_g | tlb_r_asid==asid_q) & tlb_r_vppn==vppn_q.
  - On hit in S_CMP: tlbsrch_ready=1, srch_hit=1, srch_index=i, then IDLE.
  - On miss with i==TLBNUM-1: ready with srch_hit=0, srch_index=0, then IDLE.
  - Otherwise i+1 and back to S_RD.
- INVTLB, illegal op:
  - op > 6 goes IDLE→I_DONE with no array access.
  - invtlb_ready=1 and inv_illegal=1.
- INVTLB, legal ops: I_RD (read i) → I_CMP. Match rules per op:
  - ops 0, 1: always match.
  - op 2: e & g.
  - op 3: e & ~g.
  - op 4: e & ~g & asid match.
  - op 5: e & ~g & asid match & vppn match.
  - op 6: e & (g | asid match) & vppn match.
- INVTLB, walk:
  - A match goes to I_WR: tlb_we=1, tlb_wsel=1, tlb_idx=i.
  - After I_CMP (no match) or I_WR: if i==TLBNUM-1 go to I_DONE, else i+1 and back to I_RD.
  - I_DONE pulses invtlb_ready (inv_illegal=0), then IDLE.
- srch_hit, srch_index and inv_illegal are registered and hold until the next completion. Ready pulses are one cycle wide.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Request accepted at edge T. Ready pulses then arrive at:
  - TLBRD: cycle T+2.
  - TLBWR / TLBFILL: cycle T+1.
  - TLBSRCH hit at entry i: T+2+2i. Miss: T+2·TLBNUM.
  - INVTLB with m matches: I_DONE at T+2·TLBNUM+m+1. Illegal op: T+1.
- flush:
  - Any state goes to IDLE at the next edge; no ready is issued.
  - Array enables asserted in the flush cycle still take effect; a write in progress is not cancelled.
  - A valid coincident with flush is dropped.
- Reset asserted mid-walk: immediate return to IDLE, all outputs 0.
- The entry counter wraps only via completion, never TLBNUM-1→0 inside a walk.

## Test plan
- TLBNUM=16. Write entry 5 via TLBWR (csr_index=5) → tlb_we=1, wsel=0, idx=5, tlbwr_ready in the same cycle (T+1).
- Model: entry 9 holds vppn 0x1234, asid 3, g=0, e=1. TLBSRCH with csr_vppn=0x1234, csr_asid=3 → srch_hit=1, srch_index=9, ready at T+20. Repeat with csr_asid=4 → srch_hit=0, ready at T+32.
- Model: entries 2 and 7 have g=1, all entries e=1. INVTLB op=2 → exactly two writes with wsel=1 (idx 2, then 7), invtlb_ready at T+35.
- INVTLB op=7 → invtlb_ready and inv_illegal at T+1, no tlb_re/tlb_we.
- tlbsrch_valid and tlbrd_valid in the same cycle → search runs, RD is never performed. Then tlbfill_valid while busy → ignored.
- flush during S_CMP of entry 4 → IDLE next cycle, no tlbsrch_ready, busy=0. A following TLBRD completes normally at T+2.
